// File: rtl/drw_cmd_seq_if.sv
// Draw-command sequencer bus bundle.
// Groups the command-FIFO pop interface, the parameter-write bus and the
// block-transfer handshake.
//   master : sequencer side (pops FIFO, writes parameters, starts transfers)
//   slave  : environment side (FIFO, parameter register file, blitter)
interface drw_cmd_seq_if;
  logic        FIFO_RD;
  logic        FIFO_VALID;
  logic [31:0] FIFO_DOUT;
  logic        PARAM_WE;
  logic [7:0]  PARAM_OP;
  logic [1:0]  PARAM_IDX;
  logic [31:0] PARAM_DATA;
  logic        BLT_START;
  logic        BLT_FINISH;
  logic        BLT_ABORT;

  modport master (
    output FIFO_RD, PARAM_WE, PARAM_OP, PARAM_IDX, PARAM_DATA, BLT_START, BLT_ABORT,
    input  FIFO_VALID, FIFO_DOUT, BLT_FINISH
  );

  modport slave (
    input  FIFO_RD, PARAM_WE, PARAM_OP, PARAM_IDX, PARAM_DATA, BLT_START, BLT_ABORT,
    output FIFO_VALID, FIFO_DOUT, BLT_FINISH
  );
endinterface

// File: rtl/drw_cmd_seq.sv
// Draw-command sequencer.
// Pops command words from the command FIFO, decodes the opcode in
// word[31:24], collects the argument words given by the length table and
// forwards every accepted word to the parameter register file one cycle
// later. Blit commands (0x81, 0x82) hand off to the blitter with a start
// pulse and wait for its completion. Protocol errors end the list with a
// code in ERRNO = {class, opcode}.
//
// Ports:
//   ACLK, ARST   clock, synchronous active-high reset
//   EXE          start pulse (honoured in S_IDLE only)
//   RST          soft reset, same effect as ARST
//   DRAW_FINISH  list finished or aborted on error
//   ERRNO        {class[7:0], opcode[7:0]}, 0 when no error
//   CMD_CNT      completed commands, saturating
//   bus          FIFO pop, parameter write and blit handshake (master side)
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for EXE
// S_FETCH    | popping a command header
// S_ARGS     | popping argument words, starvation timer running
// S_BLTISSUE | one cycle before the start pulse is presented
// S_BLTWAIT  | blit running, waiting for BLT_FINISH
// S_FINISH   | EODL seen, hold until reset
// S_ERROR    | protocol error, hold until reset
module drw_cmd_seq #(
  parameter bit          STRICT      = 1'b1,
  parameter int unsigned ARG_TIMEOUT = 1024,
  parameter int unsigned BLT_TIMEOUT = 0
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic          EXE,
  input  logic          RST,
  output logic          DRAW_FINISH,
  output logic [15:0]   ERRNO,
  output logic [15:0]   CMD_CNT,
  drw_cmd_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ARGS, S_BLTISSUE, S_BLTWAIT, S_FINISH, S_ERROR
  } state_t;

  localparam logic [7:0]  OP_EODL = 8'h0F;
  localparam logic [15:0] ARG_LIM = 16'(ARG_TIMEOUT - 1);
  localparam logic [31:0] BLT_LIM = (BLT_TIMEOUT == 0) ? 32'd0 : 32'(BLT_TIMEOUT - 1);

  // {known, argument count}
  function automatic logic [2:0] decode(input logic [7:0] op);
    case (op)
      8'h00, 8'h0F, 8'h24, 8'h26:        decode = 3'b100;
      8'h22, 8'h23:                      decode = 3'b101;
      8'h20, 8'h21, 8'h25, 8'h27, 8'h81: decode = 3'b110;
      8'h82:                             decode = 3'b111;
      default:                           decode = 3'b000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  rem_q, rem_d;
  logic [1:0]  argn_q, argn_d;
  logic [15:0] arg_tmo_q, arg_tmo_d;
  logic [31:0] blt_tmo_q, blt_tmo_d;
  logic [15:0] errno_q, errno_d;
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic        param_we_q, param_we_d;
  logic [7:0]  param_op_q, param_op_d;
  logic [1:0]  param_idx_q, param_idx_d;
  logic [31:0] param_data_q, param_data_d;
  logic        blt_start_q, blt_start_d;

  logic        rst;
  logic        accept;
  logic        cmd_inc;
  logic [7:0]  hdr_op;
  logic [2:0]  hdr_dec;
  logic        blit_op;

  assign rst     = ARST | RST;
  assign bus.FIFO_RD = (state_q == S_FETCH) || (state_q == S_ARGS);
  assign accept  = bus.FIFO_RD & bus.FIFO_VALID;
  assign hdr_op  = bus.FIFO_DOUT[31:24];
  assign hdr_dec = decode(hdr_op);
  assign blit_op = (op_q == 8'h81) || (op_q == 8'h82);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rem_d        = rem_q;
    argn_d       = argn_q;
    arg_tmo_d    = arg_tmo_q;
    blt_tmo_d    = blt_tmo_q;
    errno_d      = errno_q;
    cmd_inc      = 1'b0;
    param_we_d   = accept;
    param_op_d   = param_op_q;
    param_idx_d  = param_idx_q;
    param_data_d = accept ? bus.FIFO_DOUT : param_data_q;
    blt_start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (EXE) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (accept) begin
          op_d        = hdr_op;
          param_op_d  = hdr_op;
          param_idx_d = 2'd0;
          if (hdr_op == OP_EODL) begin
            cmd_inc = 1'b1;
            state_d = S_FINISH;
          end else if (!hdr_dec[2] && STRICT) begin
            errno_d = {8'h01, hdr_op};
            state_d = S_ERROR;
          end else if (hdr_dec[1:0] == 2'd0) begin
            cmd_inc = 1'b1;
          end else begin
            rem_d     = hdr_dec[1:0];
            argn_d    = 2'd1;
            arg_tmo_d = 16'd0;
            state_d   = S_ARGS;
          end
        end
      end
      S_ARGS: begin
        if (accept) begin
          param_op_d  = op_q;
          param_idx_d = argn_q;
          argn_d      = argn_q + 2'd1;
          rem_d       = rem_q - 2'd1;
          arg_tmo_d   = 16'd0;
          if (rem_q == 2'd1) begin
            cmd_inc = 1'b1;
            state_d = blit_op ? S_BLTISSUE : S_FETCH;
          end
        end else if (arg_tmo_q == ARG_LIM) begin
          errno_d = {8'h02, op_q};
          state_d = S_ERROR;
        end else begin
          arg_tmo_d = arg_tmo_q + 16'd1;
        end
      end
      S_BLTISSUE: begin
        // start is registered so the last parameter write lands first
        blt_start_d = 1'b1;
        blt_tmo_d   = 32'd0;
        state_d     = S_BLTWAIT;
      end
      S_BLTWAIT: begin
        if (bus.BLT_FINISH) begin
          state_d = S_FETCH;
        end else if ((BLT_TIMEOUT != 0) && (blt_tmo_q == BLT_LIM)) begin
          errno_d = {8'h03, op_q};
          state_d = S_ERROR;
        end else begin
          blt_tmo_d = blt_tmo_q + 32'd1;
        end
      end
      default: ;
    endcase

    cmd_cnt_d = (cmd_inc && (cmd_cnt_q != 16'hFFFF)) ? cmd_cnt_q + 16'd1 : cmd_cnt_q;
  end

  always_ff @(posedge ACLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 8'd0;
      rem_q        <= 2'd0;
      argn_q       <= 2'd0;
      arg_tmo_q    <= 16'd0;
      blt_tmo_q    <= 32'd0;
      errno_q      <= 16'd0;
      cmd_cnt_q    <= 16'd0;
      param_we_q   <= 1'b0;
      param_op_q   <= 8'd0;
      param_idx_q  <= 2'd0;
      param_data_q <= 32'd0;
      blt_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      argn_q       <= argn_d;
      arg_tmo_q    <= arg_tmo_d;
      blt_tmo_q    <= blt_tmo_d;
      errno_q      <= errno_d;
      cmd_cnt_q    <= cmd_cnt_d;
      param_we_q   <= param_we_d;
      param_op_q   <= param_op_d;
      param_idx_q  <= param_idx_d;
      param_data_q <= param_data_d;
      blt_start_q  <= blt_start_d;
    end
  end

  assign DRAW_FINISH    = (state_q == S_FINISH) || (state_q == S_ERROR);
  assign ERRNO          = errno_q;
  assign CMD_CNT        = cmd_cnt_q;
  assign bus.PARAM_WE   = param_we_q;
  assign bus.PARAM_OP   = param_op_q;
  assign bus.PARAM_IDX  = param_idx_q;
  assign bus.PARAM_DATA = param_data_q;
  assign bus.BLT_START  = blt_start_q;
  // abort is only meaningful while the blitter may be busy
  assign bus.BLT_ABORT  = rst && ((state_q == S_BLTISSUE) || (state_q == S_BLTWAIT));

endmodule

// File: tb/tb_drw_cmd_seq.sv
// Bench for drw_cmd_seq. Two instances: u0 strict with a short argument
// timeout and no blit timeout; u1 lenient with a 16-cycle blit timeout.
// Expected parameter writes come from a word-list model and are checked
// by a per-instance monitor as the DUT emits them.
module tb_drw_cmd_seq;

  typedef struct { logic [31:0] word; int gap; } fent_t;
  typedef struct { logic [7:0] op; logic [1:0] idx; logic [31:0] data; bit blit_last; } xent_t;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        exe   [2];
  logic        rst_s [2];
  logic        fin   [2];
  logic [15:0] errno [2];
  logic [15:0] cmdc  [2];
  logic        rd_w [2], abort_w [2], we_w [2];

  fent_t fifo_q [2][$];
  xent_t exp_q  [2][$];
  fent_t pb [$];

  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  int          argtab [logic [7:0]];
  logic [7:0]  known_ops [11];
  logic [15:0] exp_err [2];
  int          exp_cmd [2];
  int          blt_delay [2];
  bit          acc_p [2], gap_ld [2], busy [2], fin_drv [2], due_v [2];
  int          cur_gap [2], bcnt [2], due_c [2], wr_cnt [2], first_wr [2], last_wr [2];
  int          start_n [2], start_cyc [2];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL u%0d %s: got %0h expected %0h (t=%0t)", g, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    drw_cmd_seq_if bus ();

    drw_cmd_seq #(
      .STRICT      (g == 0),
      .ARG_TIMEOUT ((g == 0) ? 8 : 1024),
      .BLT_TIMEOUT ((g == 0) ? 0 : 16)
    ) dut (
      .ACLK        (aclk),
      .ARST        (arst),
      .EXE         (exe[g]),
      .RST         (rst_s[g]),
      .DRAW_FINISH (fin[g]),
      .ERRNO       (errno[g]),
      .CMD_CNT     (cmdc[g]),
      .bus         (bus)
    );

    assign rd_w[g]        = bus.FIFO_RD;
    assign abort_w[g]     = bus.BLT_ABORT;
    assign we_w[g]        = bus.PARAM_WE;
    assign bus.BLT_FINISH = fin_drv[g];

    // FIFO model: decide acceptance at one negedge, pop at the next
    always @(negedge aclk) begin : fifo_drv
      bit vld;
      if (acc_p[g]) begin
        if (fifo_q[g].size() > 0) void'(fifo_q[g].pop_front());
        acc_p[g]  = 1'b0;
        gap_ld[g] = 1'b0;
      end
      if (fifo_q[g].size() > 0 && !gap_ld[g]) begin
        cur_gap[g] = fifo_q[g][0].gap;
        gap_ld[g]  = 1'b1;
      end
      vld = 1'b0;
      if (fifo_q[g].size() > 0) begin
        if (cur_gap[g] > 0) cur_gap[g]--;
        else vld = 1'b1;
      end
      bus.FIFO_VALID = vld;
      bus.FIFO_DOUT  = vld ? fifo_q[g][0].word : 32'hDEAD_BEEF;
      acc_p[g] = vld && bus.FIFO_RD && !arst && !rst_s[g];
    end

    // parameter-write and blit-start monitor
    always @(negedge aclk) begin : mon
      xent_t e;
      if (bus.BLT_START) begin
        start_n[g]++;
        start_cyc[g] = cyc;
      end
      if (due_v[g] && cyc == due_c[g]) begin
        check(g, "blt_start_timing", bus.BLT_START, 1);
        due_v[g] = 1'b0;
      end else if (bus.BLT_START) begin
        check(g, "blt_start_spurious", bus.BLT_START, 0);
      end
      if (bus.PARAM_WE) begin
        if (exp_q[g].size() == 0) begin
          check(g, "param_we_spurious", bus.PARAM_WE, 0);
        end else begin
          e = exp_q[g].pop_front();
          check(g, "param_op",   bus.PARAM_OP,   e.op);
          check(g, "param_idx",  bus.PARAM_IDX,  e.idx);
          check(g, "param_data", bus.PARAM_DATA, e.data);
          if (e.blit_last) begin
            due_v[g] = 1'b1;
            due_c[g] = cyc + 1;
          end
          if (wr_cnt[g] == 0) first_wr[g] = cyc;
          last_wr[g] = cyc;
          wr_cnt[g]++;
        end
      end
    end

    // blitter: answers each start after blt_delay cycles
    always @(negedge aclk) begin : blt
      if (fin_drv[g]) begin
        fin_drv[g] = 1'b0;
        check(g, "rd_resume", bus.FIFO_RD, 1);
      end
      if (bus.BLT_START) begin
        busy[g] = 1'b1;
        bcnt[g] = blt_delay[g];
      end
      if (busy[g]) begin
        check(g, "rd_during_blt", bus.FIFO_RD, 0);
        if (bcnt[g] == 0) begin
          fin_drv[g] = 1'b1;
          busy[g]    = 1'b0;
        end else begin
          bcnt[g]--;
        end
      end
    end
  end

  task automatic add(input logic [31:0] w, input int gap);
    fent_t f;
    f.word = w;
    f.gap  = gap;
    pb.push_back(f);
  endtask

  // word-list reference: walks the list header/argument by header/argument
  task automatic model(input int g);
    int rem = 0, k = 0, n;
    logic [7:0] op = 8'h00;
    logic [31:0] w;
    xent_t x;
    exp_err[g] = 16'h0;
    exp_cmd[g] = 0;
    foreach (pb[i]) fifo_q[g].push_back(pb[i]);
    foreach (pb[i]) begin
      w = pb[i].word;
      if (rem == 0) begin
        op = w[31:24];
        x.op = op; x.idx = 2'd0; x.data = w; x.blit_last = 1'b0;
        exp_q[g].push_back(x);
        if (!argtab.exists(op) && g == 0) begin
          exp_err[g] = {8'h01, op};
          break;
        end
        n = argtab.exists(op) ? argtab[op] : 0;
        if (n == 0) begin
          exp_cmd[g]++;
          if (op == 8'h0F) break;
        end else begin
          rem = n;
          k   = 1;
        end
      end else begin
        x.op = op; x.idx = k[1:0]; x.data = w;
        x.blit_last = (rem == 1) && (op == 8'h81 || op == 8'h82);
        exp_q[g].push_back(x);
        k++;
        rem--;
        if (rem == 0) exp_cmd[g]++;
      end
    end
    if (rem != 0) exp_err[g] = {8'h02, op};
  endtask

  task automatic gen_prog(input int g, input int ncmd, input int maxgap);
    logic [7:0] op;
    int n;
    pb.delete();
    for (int c = 0; c < ncmd; c++) begin
      if (g == 1 && $urandom_range(0, 4) == 0) begin
        op = 8'($urandom);
        if (op == 8'h0F) op = 8'h00;
      end else begin
        op = known_ops[$urandom_range(0, 10)];
      end
      n = argtab.exists(op) ? argtab[op] : 0;
      add({op, 24'($urandom)}, int'($urandom_range(0, maxgap)));
      for (int a = 0; a < n; a++) add($urandom, int'($urandom_range(0, maxgap)));
    end
    add(32'h0F00_0000, 0);
  endtask

  task automatic soft_reset(input int g, input bit chk);
    @(negedge aclk);
    rst_s[g] = 1'b1;
    if (chk) begin
      #1;
      check(g, "blt_abort", abort_w[g], 1);
    end
    @(posedge aclk);
    #1;
    fifo_q[g].delete();
    exp_q[g].delete();
    acc_p[g] = 0; gap_ld[g] = 0; busy[g] = 0; fin_drv[g] = 0; due_v[g] = 0;
    wr_cnt[g] = 0; start_n[g] = 0;
    @(negedge aclk);
    rst_s[g] = 1'b0;
    if (chk) begin
      check(g, "rst_finish", fin[g],   0);
      check(g, "rst_errno",  errno[g], 0);
      check(g, "rst_cmdcnt", cmdc[g],  0);
      check(g, "rst_rd",     rd_w[g],  0);
      check(g, "rst_abort",  abort_w[g], 0);
    end
  endtask

  task automatic go(input int g);
    @(negedge aclk);
    exe[g] = 1'b1;
    @(negedge aclk);
    exe[g] = 1'b0;
  endtask

  task automatic wait_finish(input int g, input int maxc, output int fc);
    int n = 0;
    fc = -1;
    while (fin[g] !== 1'b1 && n < maxc) begin
      @(negedge aclk);
      n++;
    end
    if (fin[g] === 1'b1) fc = cyc;
    else check(g, "finish_timeout", fin[g], 1);
  endtask

  task automatic run_prog(input int g, input int maxc, output int fc);
    soft_reset(g, 0);
    model(g);
    go(g);
    wait_finish(g, maxc, fc);
    @(negedge aclk);
  endtask

  task automatic end_checks(input int g);
    check(g, "draw_finish", fin[g],   1);
    check(g, "errno",       errno[g], exp_err[g]);
    check(g, "cmd_cnt",     cmdc[g],  exp_cmd[g]);
    check(g, "writes_left", exp_q[g].size(), 0);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int fc;
    argtab[8'h00] = 0; argtab[8'h0F] = 0; argtab[8'h20] = 2; argtab[8'h21] = 2;
    argtab[8'h22] = 1; argtab[8'h23] = 1; argtab[8'h24] = 0; argtab[8'h25] = 2;
    argtab[8'h26] = 0; argtab[8'h27] = 2; argtab[8'h81] = 2; argtab[8'h82] = 3;
    known_ops = '{8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h81, 8'h82};
    for (int k = 0; k < 2; k++) begin
      exe[k] = 0; rst_s[k] = 0; blt_delay[k] = 0; acc_p[k] = 0; gap_ld[k] = 0;
      busy[k] = 0; fin_drv[k] = 0; due_v[k] = 0; wr_cnt[k] = 0; start_n[k] = 0;
      cur_gap[k] = 0; bcnt[k] = 0; start_cyc[k] = 0; first_wr[k] = 0; last_wr[k] = 0;
    end

    repeat (3) @(negedge aclk);
    arst = 1'b0;
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      check(k, "reset_finish", fin[k],   0);
      check(k, "reset_errno",  errno[k], 0);
      check(k, "reset_cmdcnt", cmdc[k],  0);
      check(k, "reset_rd",     rd_w[k],  0);
      check(k, "reset_we",     we_w[k],  0);
    end

    // basic list, back-to-back writes
    pb.delete();
    add(32'h2000_0000, 0); add(32'h0000_1000, 0); add(32'h0280_0168, 0); add(32'h0F00_0000, 0);
    run_prog(0, 100, fc);
    end_checks(0);
    check(0, "b2b_writes", wr_cnt[0], 4);
    check(0, "b2b_span",   last_wr[0] - first_wr[0], 3);

    // BITBLT with a long transfer
    blt_delay[0] = 50;
    pb.delete();
    add(32'h8200_0000, 0); add(32'h1111_1111, 0); add(32'h2222_2222, 1); add(32'h3333_3333, 0);
    add(32'h0F00_0000, 0);
    run_prog(0, 200, fc);
    end_checks(0);
    check(0, "blt_starts", start_n[0], 1);

    // unknown opcode, strict
    pb.delete();
    add(32'h5500_0000, 0); add(32'h0F00_0000, 0);
    run_prog(0, 100, fc);
    end_checks(0);
    repeat (3) @(negedge aclk);
    check(0, "err_rd_idle", rd_w[0], 0);
    check(0, "err_no_pop",  fifo_q[0].size(), 1);

    // unknown opcode, lenient
    pb.delete();
    add(32'h5500_0000, 0); add(32'h2300_0000, 2); add(32'h1234_5678, 0); add(32'h0F00_0000, 0);
    run_prog(1, 100, fc);
    end_checks(1);

    // argument starvation
    pb.delete();
    add(32'h2300_0000, 0);
    run_prog(0, 100, fc);
    end_checks(0);
    check(0, "arg_timeout_cycles", fc - last_wr[0], 8);

    // gap one short of the timeout
    pb.delete();
    add(32'h2300_0000, 0); add(32'hCAFE_0001, 7); add(32'h0F00_0000, 0);
    run_prog(0, 100, fc);
    end_checks(0);

    // soft reset while the blitter is busy, then restart cleanly
    blt_delay[0] = 1000;
    pb.delete();
    add(32'h8100_0000, 0); add(32'h0000_00AA, 0); add(32'h0000_00BB, 0); add(32'h0F00_0000, 0);
    soft_reset(0, 0);
    model(0);
    go(0);
    for (int n = 0; n < 50 && start_n[0] == 0; n++) @(negedge aclk);
    check(0, "abort_setup_start", start_n[0], 1);
    repeat (3) @(negedge aclk);
    check(0, "abort_setup_cmdcnt", cmdc[0], 1);
    soft_reset(0, 1);

    // randomized lists on both instances
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < 2; g++) begin
        blt_delay[g] = $urandom_range(0, 10);
        gen_prog(g, 20, (g == 0) ? 3 : 5);
        run_prog(g, 3000, fc);
        end_checks(g);
      end
    end

    // blit that never completes, lenient instance times out
    blt_delay[1] = 1000;
    pb.delete();
    add(32'h8100_0000, 0); add(32'h0000_0010, 0); add(32'h0000_0020, 0);
    run_prog(1, 200, fc);
    exp_err[1] = 16'h0381;
    end_checks(1);
    check(1, "blt_timeout_cycles", fc - start_cyc[1], 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drw_cmd_seq.md
Name: drw_cmd_seq

Overview:
- Parametrised draw-command sequencer.
- Pops 32-bit command words from the command-buffer FIFO, decodes the opcode in word[31:24], and counts argument words from a length table.
- Forwards every header and argument word on a generic parameter-write bus to the draw parameter register file.
- Issues block-transfer start/wait handshakes and detects protocol errors (unknown opcode, argument starvation, transfer hang), reporting them through ERRNO.

Parameters:
- STRICT, 1: 1 = unknown opcode is an error; 0 = unknown opcode is treated as a zero-argument NOP.
- ARG_TIMEOUT, 1024: max consecutive cycles without FIFO_VALID while in S_ARGS before error. Range 1..65535.
- BLT_TIMEOUT, 0: max cycles in S_BLTWAIT before error. 0 disables the check.

Ports:
- ACLK in 1: clock.
- ARST in 1: reset, synchronous, active-high.
- EXE in 1: start pulse from regctrl; honoured only in S_IDLE.
- RST in 1: soft reset from regctrl; same effect as ARST.
- DRAW_FINISH out 1: high in S_FINISH or S_ERROR.
- ERRNO out 16: {class[7:0], opcode[7:0]}; 0 when no error.
- CMD_CNT out 16: count of completed commands, saturating.
- FIFO_RD out 1: pop request.
- FIFO_VALID in 1: FIFO_DOUT valid. A word is accepted in any cycle where FIFO_RD && FIFO_VALID.
- FIFO_DOUT in 32: FIFO data.
- PARAM_WE out 1: parameter write strobe.
- PARAM_OP out 8: opcode of the current command.
- PARAM_IDX out 2: 0 = header, 1..3 = argument number.
- PARAM_DATA out 32: accepted word.
- BLT_START out 1: one-cycle block-transfer start pulse.
- BLT_FINISH in 1: transfer complete.
- BLT_ABORT out 1: high while (ARST||RST) && state is S_BLTISSUE or S_BLTWAIT.

Behaviour:
- Reset (ARST or RST):
  - State S_IDLE; ERRNO=0; CMD_CNT=0; arg counter and timeout counters = 0.
  - PARAM_WE=0, PARAM_OP=0, PARAM_IDX=0, PARAM_DATA=0, BLT_START=0.
  - A reset in any state, including mid-command or mid-transfer, returns to S_IDLE with no further pops or writes.
- Opcode / argument-count table:
  - NOP 0x00 / 0; EODL 0x0F / 0.
  - SETFRAME 0x20 / 2; SETDRAWAREA 0x21 / 2; SETTEXTURE 0x22 / 1; SETFCOLOR 0x23 / 1.
  - SETSTMODE 0x24 / 0; SETSCOLOR 0x25 / 2; SETBLENDOFF 0x26 / 0; SETBLENDALPHA 0x27 / 2.
  - PATBLT 0x81 / 2; BITBLT 0x82 / 3.
  - Blit commands are 0x81 and 0x82 only.
- FIFO_RD = (state == S_FETCH) || (state == S_ARGS). Combinational from state; zero in all other states.
- S_IDLE: EXE -> S_FETCH.
- S_FETCH: on header acceptance:
  - EODL: CMD_CNT+1, -> S_FINISH.
  - Unknown opcode and STRICT=1: ERRNO = {0x01, op}, -> S_ERROR.
  - Argument count 0 (including unknown opcode with STRICT=0): CMD_CNT+1, stay S_FETCH.
  - Otherwise: load remaining count, -> S_ARGS.
  - With no word available, S_FETCH waits indefinitely; there is no timeout here.
- S_ARGS:
  - Each acceptance decrements the remaining count and increments PARAM_IDX; the timeout counter clears.
  - On acceptance of the last argument: CMD_CNT+1; blit opcode -> S_BLTISSUE, else -> S_FETCH.
  - Each non-VALID cycle increments the timeout counter. Reaching ARG_TIMEOUT: ERRNO = {0x02, op}, -> S_ERROR.
- Parameter writes:
  - Every accepted word (header, NOP, EODL and unknown headers included) produces PARAM_WE=1 in the next cycle, with PARAM_OP, PARAM_IDX and PARAM_DATA registered from that acceptance.
  - Latency is exactly 1 cycle. Back-to-back acceptances give back-to-back strobes.
- S_BLTISSUE: lasts 1 cycle and drives BLT_START=1, i.e. 2 cycles after the last argument was accepted, so the final PARAM_WE precedes the start. Then -> S_BLTWAIT.
- S_BLTWAIT:
  - BLT_FINISH -> S_FETCH. BLT_FINISH is sampled only in this state; a BLT_FINISH during S_BLTISSUE is ignored.
  - If BLT_TIMEOUT != 0 and the wait counter reaches BLT_TIMEOUT: ERRNO = {0x03, op}, -> S_ERROR.
- S_FINISH and S_ERROR: hold until reset; EXE is ignored. DRAW_FINISH=1.
- CMD_CNT saturates at 0xFFFF; further increments are dropped.
- Simultaneous reset and EXE: reset wins.

Test Plan:
- EXE, then FIFO streams 0x20000000, 0x00001000, 0x02800168, 0x0F000000 with VALID every cycle -> PARAM_WE on 4 consecutive cycles with IDX 0, 1, 2, 0; PARAM_OP 0x20, 0x20, 0x20, 0x0F; DRAW_FINISH=1; CMD_CNT=2; ERRNO=0.
- BITBLT 0x82000000 plus 3 args, BLT_FINISH held 0 for 50 cycles, then pulsed -> single BLT_START exactly 2 cycles after the 3rd arg acceptance; FIFO_RD=0 during the wait; popping resumes the cycle after BLT_FINISH.
- STRICT=1, header 0x55000000 -> ERRNO=0x0155, DRAW_FINISH=1, FIFO_RD stays 0. Repeat with STRICT=0: treated as NOP, CMD_CNT=1, parsing continues.
- ARG_TIMEOUT=8, SETFCOLOR header then VALID held low -> after 8 cycles ERRNO=0x0223, S_ERROR. Repeat with one VALID gap of 7 cycles -> no error.
- RST asserted in S_BLTWAIT -> BLT_ABORT=1 that cycle; next cycle state S_IDLE, ERRNO=0, CMD_CNT=0. A new EXE restarts cleanly.
- BLT_TIMEOUT=16, PATBLT with no BLT_FINISH -> ERRNO=0x0381 after 16 wait cycles.
